// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the decode-stage hazard scoreboard:
//   - state_t      : scoreboard FSM states (RUN, HAZARD, FLUSH)
//   - WRITES_RD    : opcode mask, bit n set when opcode n writes rd
//   - USES_R1      : opcode mask, bit n set when opcode n reads source 1
//   - USES_R2      : opcode mask, bit n set when opcode n reads source 2
//   - FLUSH_CYCLES : decode-flush duration after a taken branch
// Opcode map behind the masks:
//   0       nop              (no operands)
//   1..7    reg-reg ALU      (rd <- r1 op r2)
//   8..11   reg-imm ALU      (rd <- r1 op imm)
//   12      store            (reads r1, r2)
//   13      branch           (reads r1, r2)
//   14      load immediate   (rd <- imm)
//   15      jump             (no operands)
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int FLUSH_CYCLES = 2;

    localparam logic [15:0] WRITES_RD = 16'h4FFE;
    localparam logic [15:0] USES_R1   = 16'h3FFE;
    localparam logic [15:0] USES_R2   = 16'h30FE;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HAZARD = 2'd1,
        FLUSH  = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_scoreboard_pending_counter.sv
// ---------------------------------------------------------------------------
// pending_counter
// One saturating up/down counter tracking in-flight writes to a register.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   inc          : a writer of this register issued this cycle
//   dec          : a writeback to this register happens this cycle
//   count        : current number of pending writes
//   nonzero      : count != 0
// inc and dec together cancel; dec on zero stays at zero, inc on all-ones
// stays at all-ones.
// ---------------------------------------------------------------------------
module pending_counter #(
    parameter int CNTWIDTH = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                inc,
    input  logic                dec,
    output logic [CNTWIDTH-1:0] count,
    output logic                nonzero
);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec) begin
            if (count != '1) count <= count + 1'b1;
        end else if (dec && !inc) begin
            if (count != '0) count <= count - 1'b1;
        end
    end

    assign nonzero = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Decode-stage interlock: tracks pending register writes per register and
// stalls, bubbles or flushes the front end accordingly.
// Ports:
//   clock, reset           : clock, synchronous active-high reset
//   validD                 : decode holds a real instruction
//   opcode                 : decode opcode (indexes the package masks)
//   r1A, r2A               : decode source addresses
//   regDestinationAddress  : decode destination address
//   writeE, writeA         : writeback enable and address
//   branchTaken            : execute resolved a taken branch
//   issueD                 : decode instruction advances this cycle
//   stallF, stallD         : hold PC / hold IF-ID register
//   bubbleE                : insert a NOP into ID-EX
//   flushD                 : clear the IF-ID register
//   pendingMask            : bit i set while register i has pending writes
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REGNUM       = 8,
    parameter int ADDRESSWIDTH = 3,
    parameter int OPCODEWIDTH  = 4,
    parameter int CNTWIDTH     = 2,
    parameter int FLUSH_CYCLES = hazard_pkg::FLUSH_CYCLES
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    validD,
    input  logic [OPCODEWIDTH-1:0]  opcode,
    input  logic [ADDRESSWIDTH-1:0] r1A,
    input  logic [ADDRESSWIDTH-1:0] r2A,
    input  logic [ADDRESSWIDTH-1:0] regDestinationAddress,
    input  logic                    writeE,
    input  logic [ADDRESSWIDTH-1:0] writeA,
    input  logic                    branchTaken,
    output logic                    issueD,
    output logic                    stallF,
    output logic                    stallD,
    output logic                    bubbleE,
    output logic                    flushD,
    output logic [REGNUM-1:0]       pendingMask
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t                state, next_state;
    logic [FCW-1:0]        flush_cnt, flush_next;
    logic [CNTWIDTH-1:0]   cnt [REGNUM];
    logic [REGNUM-1:0]     inc_vec, dec_vec;

    logic writes_rd, uses_r1, uses_r2;
    logic wb_r1, wb_r2, wb_rd;
    logic haz_r1, haz_r2, haz_rd, hazard;

    // ---------------- per-register pending counters ----------------
    for (genvar i = 0; i < REGNUM; i++) begin : g_cnt
        assign inc_vec[i] = issueD && writes_rd &&
                            (regDestinationAddress == ADDRESSWIDTH'(i));
        assign dec_vec[i] = writeE && (writeA == ADDRESSWIDTH'(i));

        pending_counter #(.CNTWIDTH(CNTWIDTH)) u_cnt (
            .clock   (clock),
            .reset   (reset),
            .inc     (inc_vec[i]),
            .dec     (dec_vec[i]),
            .count   (cnt[i]),
            .nonzero (pendingMask[i])
        );
    end

    // ---------------- hazard detection ----------------
    assign writes_rd = WRITES_RD[opcode];
    assign uses_r1   = USES_R1[opcode];
    assign uses_r2   = USES_R2[opcode];

    // The register file writes on the falling edge, so a same-cycle
    // writeback to a source already delivers the value decode needs.
    assign wb_r1 = writeE && (writeA == r1A);
    assign wb_r2 = writeE && (writeA == r2A);
    assign wb_rd = writeE && (writeA == regDestinationAddress);

    assign haz_r1 = uses_r1 && (cnt[r1A] != '0) && !wb_r1;
    assign haz_r2 = uses_r2 && (cnt[r2A] != '0) && !wb_r2;
    // Destination counter full: issuing would overflow the pending count.
    assign haz_rd = writes_rd && (cnt[regDestinationAddress] == '1) && !wb_rd;

    assign hazard = validD && (haz_r1 || haz_r2 || haz_rd);

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= next_state;
            flush_cnt <= flush_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        flush_next = flush_cnt;
        issueD     = 1'b0;
        stallF     = 1'b0;
        stallD     = 1'b0;
        bubbleE    = 1'b0;
        flushD     = 1'b0;

        if (branchTaken) begin
            // A taken branch overrides any hazard: the decode slot is wrong-path.
            bubbleE    = 1'b1;
            flushD     = 1'b1;
            next_state = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            flush_next = FCW'(FLUSH_CYCLES - 1);
        end else begin
            case (state)
                FLUSH: begin
                    bubbleE = 1'b1;
                    flushD  = 1'b1;
                    if (flush_cnt <= FCW'(1)) begin
                        next_state = RUN;
                        flush_next = '0;
                    end else begin
                        flush_next = flush_cnt - 1'b1;
                    end
                end
                default: begin
                    if (!validD) begin
                        next_state = RUN;
                    end else if (hazard) begin
                        stallF     = 1'b1;
                        stallD     = 1'b1;
                        bubbleE    = 1'b1;
                        next_state = HAZARD;
                    end else begin
                        issueD     = 1'b1;
                        next_state = RUN;
                    end
                end
            endcase
        end

        if (reset) begin
            issueD  = 1'b0;
            stallF  = 1'b0;
            stallD  = 1'b0;
            bubbleE = 1'b0;
            flushD  = 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
// Drives directed and random decode/writeback/branch traffic. A reference
// model predicts each cycle's outputs from the pending-write counts and the
// remaining flush length; predictions go into a queue that a negedge monitor
// drains and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int REGNUM = 8;
    localparam int CNTMAX = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       validD;
    logic [3:0] opcode;
    logic [2:0] r1A, r2A, regDestinationAddress;
    logic       writeE;
    logic [2:0] writeA;
    logic       branchTaken;
    logic       issueD, stallF, stallD, bubbleE, flushD;
    logic [REGNUM-1:0] pendingMask;

    hazard_scoreboard dut (
        .clock                 (clock),
        .reset                 (reset),
        .validD                (validD),
        .opcode                (opcode),
        .r1A                   (r1A),
        .r2A                   (r2A),
        .regDestinationAddress (regDestinationAddress),
        .writeE                (writeE),
        .writeA                (writeA),
        .branchTaken           (branchTaken),
        .issueD                (issueD),
        .stallF                (stallF),
        .stallD                (stallD),
        .bubbleE               (bubbleE),
        .flushD                (flushD),
        .pendingMask           (pendingMask)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic              issue;
        logic              stall_f;
        logic              stall_d;
        logic              bubble;
        logic              flush;
        logic [REGNUM-1:0] mask;
    } resp_t;

    typedef struct {
        resp_t r;
        string label;
        int    cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model state: pending write count per register, and number of
    // flush cycles still owed after the branch cycle itself.
    int pend [REGNUM];
    int flush_rem;

    // ---------------- monitor ----------------
    exp_t  mon_e;
    resp_t mon_got;
    always @(negedge clock) begin
        if (q.size() > 0) begin
            mon_e   = q.pop_front();
            mon_got = {issueD, stallF, stallD, bubbleE, flushD, pendingMask};
            checks++;
            if (mon_got !== mon_e.r) begin
                errors++;
                $display("FAIL %s cycle %0d: got issue,stallF,stallD,bubble,flush=%b%b%b%b%b mask=%b, expected %b%b%b%b%b mask=%b",
                         mon_e.label, mon_e.cyc,
                         mon_got.issue, mon_got.stall_f, mon_got.stall_d, mon_got.bubble, mon_got.flush, mon_got.mask,
                         mon_e.r.issue, mon_e.r.stall_f, mon_e.r.stall_d, mon_e.r.bubble, mon_e.r.flush, mon_e.r.mask);
            end
        end
    end

    // ---------------- driver + model ----------------
    task automatic step(input logic v, input logic [3:0] op,
                        input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] d,
                        input logic we, input logic [2:0] wa,
                        input logic br, input logic rst, input string label);
        exp_t e;
        bit   hz, wants_inc;
        @(posedge clock);
        #1;
        cycle++;
        validD = v; opcode = op; r1A = a1; r2A = a2; regDestinationAddress = d;
        writeE = we; writeA = wa; branchTaken = br; reset = rst;

        e.r       = '0;
        e.label   = label;
        e.cyc     = cycle;
        for (int i = 0; i < REGNUM; i++) e.r.mask[i] = (pend[i] > 0);

        if (rst) begin
            q.push_back(e);
            for (int i = 0; i < REGNUM; i++) pend[i] = 0;
            flush_rem = 0;
            return;
        end

        // A source is blocked by a pending write unless it is being written
        // back this very cycle; a destination is blocked when its count is full.
        hz = v && ((USES_R1[op] && pend[a1] > 0 && !(we && wa == a1)) ||
                   (USES_R2[op] && pend[a2] > 0 && !(we && wa == a2)) ||
                   (WRITES_RD[op] && pend[d] == CNTMAX && !(we && wa == d)));

        if (br) begin
            e.r.bubble = 1'b1;
            e.r.flush  = 1'b1;
            flush_rem  = FLUSH_CYCLES - 1;
        end else if (flush_rem > 0) begin
            e.r.bubble = 1'b1;
            e.r.flush  = 1'b1;
            flush_rem--;
        end else if (v && hz) begin
            e.r.stall_f = 1'b1;
            e.r.stall_d = 1'b1;
            e.r.bubble  = 1'b1;
        end else if (v) begin
            e.r.issue = 1'b1;
        end
        q.push_back(e);

        wants_inc = e.r.issue && WRITES_RD[op];
        if (wants_inc && we && wa == d) begin
            // issue and writeback of the same register cancel out
        end else begin
            if (wants_inc && pend[d] < CNTMAX) pend[d]++;
            if (we && pend[wa] > 0) pend[wa]--;
        end
    endtask

    task automatic idle(input string label);
        step(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, label);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       rv, rwe, rbr, rrst;
        logic [3:0] rop;
        logic [2:0] ra1, ra2, rd, rwa;
        int         cand[$];

        for (int i = 0; i < REGNUM; i++) pend[i] = 0;
        flush_rem = 0;
        reset = 1'b1; validD = 1'b0; opcode = '0; r1A = '0; r2A = '0;
        regDestinationAddress = '0; writeE = 1'b0; writeA = '0; branchTaken = 1'b0;
        repeat (2) @(posedge clock);

        // reset held: controls forced low even with a valid branch and writer
        step(1'b1, 4'd1, 3'd0, 3'd0, 3'd1, 1'b1, 3'd1, 1'b1, 1'b1, "reset_forced");
        idle("post_reset");

        // write r3, then read r3 until its writeback 3 cycles after issue
        step(1'b1, 4'd1, 3'd0, 3'd0, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0, "raw_write");
        step(1'b1, 4'd1, 3'd3, 3'd0, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, "raw_stall1");
        step(1'b1, 4'd1, 3'd3, 3'd0, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, "raw_stall2");
        step(1'b1, 4'd1, 3'd3, 3'd0, 3'd1, 1'b1, 3'd3, 1'b0, 1'b0, "raw_issue");
        step(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0, "raw_drain");
        idle("raw_clean");

        // same-cycle writeback bypass on r2
        step(1'b1, 4'd14, 3'd0, 3'd0, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0, "byp_write");
        step(1'b1, 4'd12, 3'd0, 3'd2, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0, "byp_read");
        idle("byp_clear");

        // writeback to an idle register
        step(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd7, 1'b0, 1'b0, "wb_zero");
        idle("wb_zero_after");

        // branch during a hazard stall
        step(1'b1, 4'd14, 3'd0, 3'd0, 3'd4, 1'b0, 3'd0, 1'b0, 1'b0, "br_write");
        step(1'b1, 4'd8,  3'd4, 3'd0, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, "br_stall");
        step(1'b1, 4'd8,  3'd4, 3'd0, 3'd1, 1'b0, 3'd0, 1'b1, 1'b0, "br_taken");
        step(1'b1, 4'd0,  3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, "br_flush");
        step(1'b1, 4'd0,  3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, "br_run");
        step(1'b0, 4'd0,  3'd0, 3'd0, 3'd0, 1'b1, 3'd4, 1'b0, 1'b0, "br_wb");
        idle("br_clean");

        // validD drop during a hazard returns to RUN quietly
        step(1'b1, 4'd14, 3'd0, 3'd0, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0, "drop_write");
        step(1'b1, 4'd8,  3'd6, 3'd0, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, "drop_stall");
        idle("drop_idle");
        step(1'b0, 4'd0,  3'd0, 3'd0, 3'd0, 1'b1, 3'd6, 1'b0, 1'b0, "drop_wb");

        // saturate r5 with three writers, fourth stalls until a writeback
        for (int k = 0; k < 3; k++)
            step(1'b1, 4'd14, 3'd0, 3'd0, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0, "sat_fill");
        step(1'b1, 4'd14, 3'd0, 3'd0, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0, "sat_stall1");
        step(1'b1, 4'd14, 3'd0, 3'd0, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0, "sat_stall2");
        step(1'b1, 4'd14, 3'd0, 3'd0, 3'd5, 1'b1, 3'd5, 1'b0, 1'b0, "sat_issue");
        for (int k = 0; k < 3; k++)
            step(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd5, 1'b0, 1'b0, "sat_drain");
        idle("sat_empty");

        // reset in the first FLUSH cycle with counters nonzero
        step(1'b1, 4'd14, 3'd0, 3'd0, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0, "rst_write");
        step(1'b1, 4'd0,  3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, "rst_branch");
        step(1'b1, 4'd0,  3'd0, 3'd0, 3'd0, 1'b1, 3'd6, 1'b1, 1'b1, "rst_in_flush");
        idle("rst_after");
        step(1'b1, 4'd8,  3'd6, 3'd0, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, "rst_run_issue");
        step(1'b0, 4'd0,  3'd0, 3'd0, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0, "rst_drain");

        // random traffic; writebacks favour registers with pending writes
        for (int n = 0; n < 800; n++) begin
            rv   = ($urandom_range(0, 3) != 0);
            rop  = 4'($urandom_range(0, 15));
            ra1  = 3'($urandom_range(0, 7));
            ra2  = 3'($urandom_range(0, 7));
            rd   = 3'($urandom_range(0, 7));
            rwe  = ($urandom_range(0, 2) == 0);
            cand.delete();
            for (int i = 0; i < REGNUM; i++) if (pend[i] > 0) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 4) != 0)
                rwa = 3'(cand[$urandom_range(0, cand.size() - 1)]);
            else
                rwa = 3'($urandom_range(0, 7));
            rbr  = ($urandom_range(0, 19) == 0);
            rrst = ($urandom_range(0, 99) == 0);
            step(rv, rop, ra1, ra2, rd, rwe, rwa, rbr, rrst, "random");
        end

        @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d predictions left unchecked, expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- REGNUM, 8, register-file entries.
- ADDRESSWIDTH, 3, register address width.
- OPCODEWIDTH, 4, opcode width.
- CNTWIDTH, 2, per-register pending-write counter width.
- FLUSH_CYCLES, 2, decode-flush duration after a taken branch.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- validD  in  1  decode holds a real instruction.
- opcode  in  OPCODEWIDTH  decode opcode.
- r1A, r2A  in  ADDRESSWIDTH  decode source addresses.
- regDestinationAddress  in  ADDRESSWIDTH  decode destination.
- writeE  in  1  writeback write enable.
- writeA  in  ADDRESSWIDTH  writeback address.
- branchTaken  in  1  execute resolved a taken branch.
- issueD  out  1  decode instruction advances this cycle.
- stallF  out  1  hold PC.
- stallD  out  1  hold the IF/ID register.
- bubbleE  out  1  insert NOP into ID/EX.
- flushD  out  1  clear the IF/ID register.
- pendingMask  out  REGNUM  bit i set when pending count of reg i is nonzero.

Function
REQ-003 The block SHALL keep one CNTWIDTH-bit pending-write counter per register.

REQ-004 Opcode class SHALL come from package masks WRITES_RD, USES_R1 and USES_R2, each indexed by opcode.

REQ-005 A source SHALL count as hazardous when its mask bit is set, its counter is nonzero, and it is not being written this cycle:
- Same-cycle writeback to that register (writeE and writeA equal to the source) clears the hazard.
- Reason: the register file writes on the falling edge.

REQ-006 A structural hazard SHALL exist when the WRITES_RD bit is set and the destination counter is saturated (all ones) with no same-cycle writeback to that register.

REQ-007 FSM states SHALL be RUN, HAZARD and FLUSH; the state is registered.

REQ-008 issueD SHALL be validD AND state is not FLUSH AND no hazard AND not branchTaken, computed combinationally.

REQ-009 In RUN or HAZARD, when validD is set and a hazard is present (and branchTaken is clear):
- stallF=1, stallD=1 and bubbleE=1 that same cycle.
- Next state is HAZARD.

REQ-010 In HAZARD, when the hazard clears: issueD=1 that cycle and the next state is RUN.
- Stall latency is exactly the number of cycles until the blocking writeback, plus zero.

REQ-011 branchTaken SHALL have priority over every hazard:
- That cycle: issueD=0, bubbleE=1, flushD=1.
- Load the flush counter with FLUSH_CYCLES-1 and go to FLUSH.

REQ-012 In FLUSH:
- flushD=1, bubbleE=1, stallF=0, stallD=0, issueD=0.
- Decrement the counter each cycle; go to RUN when it reaches zero.
- A new branchTaken reloads the counter.

REQ-013 Counter update rules:
- On issueD with the WRITES_RD bit set, increment the destination counter.
- On writeE, decrement counter writeA, saturating at zero.
- Both on the same register in the same cycle leave it unchanged.

REQ-014 A writeback to a register whose counter is zero SHALL leave the counter at zero and raise no error.

REQ-015 When validD=0 outside FLUSH, all control outputs SHALL be 0 and the next state is RUN.

Reset
REQ-016 When reset is high at a clock edge:
- All counters clear to 0; state becomes RUN; the flush counter clears.
- All outputs read 0 in the following cycle.
- This takes priority over branchTaken and writeE, including mid-FLUSH or mid-HAZARD.

REQ-017 While reset is high, issueD, stallF, stallD, bubbleE and flushD SHALL be forced to 0.

Structure
REQ-018 Package hazard_pkg SHALL hold:
- The FSM state enum.
- The WRITES_RD, USES_R1 and USES_R2 opcode masks.
- FLUSH_CYCLES.

REQ-019 One sub-module, pending_counter, SHALL implement a single saturating up/down counter and be instantiated REGNUM times.

Verification
REQ-020 Write r3, then read r3 the next cycle, with r3 writeback 3 cycles after issue:
- 2 cycles of stallF=stallD=bubbleE=1.
- issueD=1 in the writeback cycle.

REQ-021 Issue a reader of r2 in the same cycle that writeE=1 with writeA=2 (counter 1 before): no stall, issueD=1, and r2's counter reaches 0.

REQ-022 branchTaken=1 during a HAZARD stall:
- flushD=1 for exactly 2 cycles with issueD=0.
- Then RUN; the pending counters are unchanged.

REQ-023 Issue 3 writers of r5 with no writeback:
- pendingMask[5]=1 and the counter is 3.
- A 4th writer of r5 stalls until writeE with writeA=5.

REQ-024 Assert reset in the first FLUSH cycle with counters nonzero:
- The next cycle shows state RUN, all outputs 0 and pendingMask=0.
